// File: rtl/enc_gray_wptr.sv
// Write-side pointer stage for an async FIFO: binary/Gray write pointer, read-pointer
// synchroniser with Gray-to-binary decode, registered full flag and fill level.
module enc_gray_wptr #(
    parameter int ADDR_W      = 9,
    parameter int PTR_W       = ADDR_W + 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [PTR_W-1:0]  rptr_gray_async,
    output logic              wr_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [PTR_W-1:0]  wptr_bin,
    output logic [PTR_W-1:0]  wptr_gray,
    output logic              full,
    output logic [PTR_W-1:0]  wr_level
);

    // Stage 0 samples the foreign-domain bus; stage SYNC_STAGES-1 is the safe copy.
    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    logic [PTR_W-1:0]                  rsync_gray;
    logic [PTR_W-1:0]                  rbin;
    logic [PTR_W-1:0]                  bin_next;
    logic [PTR_W-1:0]                  gray_next;
    logic [PTR_W-1:0]                  full_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rsync_gray = sync_q[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it; flat form avoids a
    // ripple through a self-referencing vector.
    for (genvar i = 0; i < PTR_W; i++) begin : g_decode
        assign rbin[i] = ^rsync_gray[PTR_W-1:i];
    end

    assign wr_en     = wr_req & ~full;
    assign waddr     = wptr_bin[ADDR_W-1:0];
    assign bin_next  = wptr_bin + {{(PTR_W-1){1'b0}}, wr_en};
    assign gray_next = bin_next ^ (bin_next >> 1);

    // Write pointer exactly one depth ahead of the read pointer, expressed in Gray.
    assign full_match = {~rsync_gray[PTR_W-1:PTR_W-2], rsync_gray[PTR_W-3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            wr_level  <= '0;
        end else begin
            wptr_bin  <= bin_next;
            wptr_gray <= gray_next;
            full      <= (gray_next == full_match);
            wr_level  <= bin_next - rbin;
        end
    end

endmodule

// File: tb/tb_enc_gray_wptr.sv
// Bench for enc_gray_wptr: directed scenarios plus randomized producer/reader traffic
// checked against an occupancy-count reference model.
module tb_enc_gray_wptr;
    localparam int ADDR_W = 9;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PMOD   = 1 << PTR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [PTR_W-1:0]  rptr_gray_async;
    logic              wr_en;
    logic [ADDR_W-1:0] waddr;
    logic [PTR_W-1:0]  wptr_bin;
    logic [PTR_W-1:0]  wptr_gray;
    logic              full;
    logic [PTR_W-1:0]  wr_level;

    enc_gray_wptr #(.ADDR_W(ADDR_W), .PTR_W(PTR_W), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rptr_gray_async(rptr_gray_async),
        .wr_en(wr_en), .waddr(waddr), .wptr_bin(wptr_bin), .wptr_gray(wptr_gray),
        .full(full), .wr_level(wr_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: write count, read pointer as seen after the synchroniser delay.
    int  m_w     = 0;
    int  m_level = 0;
    bit  m_full  = 0;
    int  q[$];
    bit  exp_wen, obs_wen;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic cyc(input bit r, input bit req, input int rb);
        int rs;
        rst = r;
        wr_req = req;
        rptr_gray_async = PTR_W'(gray(rb));
        #2;
        obs_wen = wr_en;
        exp_wen = req && !m_full;
        @(posedge clk);
        if (r) begin
            m_w = 0; m_level = 0; m_full = 0;
            q.delete();
            repeat (SYNC) q.push_back(0);
        end else begin
            rs = q.pop_front();
            q.push_back(rb);
            if (exp_wen) m_w = (m_w + 1) % PMOD;
            m_level = (m_w - rs + PMOD) % PMOD;
            m_full  = (m_level == DEPTH);
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        total++; if (obs_wen !== 1'b1) begin bad++; $display("FAIL reset_wr_en: got %0b exp 1", obs_wen); end
        total++; if (wptr_bin !== '0) begin bad++; $display("FAIL reset_bin: got %0h exp 0", wptr_bin); end
        total++; if (wptr_gray !== '0) begin bad++; $display("FAIL reset_gray: got %0h exp 0", wptr_gray); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b exp 0", full); end
        total++; if (wr_level !== '0) begin bad++; $display("FAIL reset_level: got %0d exp 0", wr_level); end
        cyc(0, 0, 0);
        total++; if (wptr_bin !== '0) begin bad++; $display("FAIL reset_idle_bin: got %0h exp 0", wptr_bin); end
    endtask

    task automatic test_five_writes();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0);
            total++; if (obs_wen !== 1'b1) begin bad++; $display("FAIL five_wr_en: got %0b exp 1", obs_wen); end
        end
        total++; if (wptr_bin !== 10'd5) begin bad++; $display("FAIL five_bin: got %0h exp 5", wptr_bin); end
        total++; if (wptr_gray !== 10'h007) begin bad++; $display("FAIL five_gray: got %0h exp 7", wptr_gray); end
        total++; if (waddr !== 9'd5) begin bad++; $display("FAIL five_waddr: got %0h exp 5", waddr); end
        total++; if (wr_level !== 10'd5) begin bad++; $display("FAIL five_level: got %0d exp 5", wr_level); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL five_full: got %0b exp 0", full); end
    endtask

    task automatic test_fill();
        cyc(1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 0);
            total++; if (full !== (i == DEPTH - 1)) begin bad++; $display("FAIL fill_full[%0d]: got %0b exp %0b", i, full, i == DEPTH - 1); end
            total++; if (wptr_bin !== PTR_W'(m_w)) begin bad++; $display("FAIL fill_bin[%0d]: got %0h exp %0h", i, wptr_bin, m_w); end
        end
        total++; if (wptr_bin !== 10'h200) begin bad++; $display("FAIL fill_bin_end: got %0h exp 200", wptr_bin); end
        total++; if (wptr_gray !== 10'h300) begin bad++; $display("FAIL fill_gray_end: got %0h exp 300", wptr_gray); end
        total++; if (wr_level !== 10'd512) begin bad++; $display("FAIL fill_level_end: got %0d exp 512", wr_level); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0);
            total++; if (obs_wen !== 1'b0) begin bad++; $display("FAIL fill_refuse_wr_en: got %0b exp 0", obs_wen); end
            total++; if (wptr_bin !== 10'h200) begin bad++; $display("FAIL fill_hold_bin: got %0h exp 200", wptr_bin); end
            total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_hold_full: got %0b exp 1", full); end
        end
    endtask

    task automatic test_release();
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1);
            total++; if (full !== (k < 3)) begin bad++; $display("FAIL release_full[%0d]: got %0b exp %0b", k, full, k < 3); end
        end
        total++; if (wr_level !== 10'd511) begin bad++; $display("FAIL release_level: got %0d exp 511", wr_level); end
        cyc(0, 1, 1);
        total++; if (obs_wen !== 1'b1) begin bad++; $display("FAIL release_wr_en: got %0b exp 1", obs_wen); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL release_refull: got %0b exp 1", full); end
        total++; if (wptr_bin !== 10'h201) begin bad++; $display("FAIL release_bin: got %0h exp 201", wptr_bin); end
    endtask

    task automatic test_wrap_random();
        int rd = 1;
        int wraps = 0;
        logic [PTR_W-1:0] pbin, pgray;
        bit req;
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 3) != 0);
            if (rd != m_w && $urandom_range(0, 7) < ((i % 512) < 256 ? 2 : 7))
                rd = (rd + 1) % PMOD;
            pbin = wptr_bin;
            pgray = wptr_gray;
            cyc(0, req, rd);
            total++; if (obs_wen !== exp_wen) begin bad++; $display("FAIL rnd_wr_en[%0d]: got %0b exp %0b", i, obs_wen, exp_wen); end
            total++; if (wptr_bin !== PTR_W'(m_w)) begin bad++; $display("FAIL rnd_bin[%0d]: got %0h exp %0h", i, wptr_bin, m_w); end
            total++; if (wptr_gray !== PTR_W'(gray(m_w))) begin bad++; $display("FAIL rnd_gray[%0d]: got %0h exp %0h", i, wptr_gray, gray(m_w)); end
            total++; if (waddr !== ADDR_W'(m_w % DEPTH)) begin bad++; $display("FAIL rnd_waddr[%0d]: got %0h exp %0h", i, waddr, m_w % DEPTH); end
            total++; if (full !== m_full) begin bad++; $display("FAIL rnd_full[%0d]: got %0b exp %0b", i, full, m_full); end
            total++; if (wr_level !== PTR_W'(m_level)) begin bad++; $display("FAIL rnd_level[%0d]: got %0d exp %0d", i, wr_level, m_level); end
            if (pbin == 10'h3FF && wptr_bin == 10'h000) begin
                wraps++;
                total++; if (pgray !== 10'h200 || wptr_gray !== 10'h000) begin bad++; $display("FAIL wrap_gray: got %0h->%0h exp 200->0", pgray, wptr_gray); end
            end
        end
        total++; if (wraps == 0) begin bad++; $display("FAIL wrap_seen: got %0d exp >0", wraps); end
    endtask

    task automatic test_midop_reset();
        cyc(1, 0, 0);
        for (int i = 0; i < 100; i++) cyc(0, 1, 0);
        total++; if (wptr_bin !== 10'd100) begin bad++; $display("FAIL midop_pre_bin: got %0d exp 100", wptr_bin); end
        cyc(1, 1, 0);
        total++; if (wptr_bin !== '0) begin bad++; $display("FAIL midop_bin: got %0h exp 0", wptr_bin); end
        total++; if (wptr_gray !== '0) begin bad++; $display("FAIL midop_gray: got %0h exp 0", wptr_gray); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL midop_full: got %0b exp 0", full); end
        total++; if (wr_level !== '0) begin bad++; $display("FAIL midop_level: got %0d exp 0", wr_level); end
        for (int i = 0; i < 3; i++) cyc(0, 1, 0);
        total++; if (wptr_bin !== 10'd3) begin bad++; $display("FAIL midop_resume_bin: got %0d exp 3", wptr_bin); end
        total++; if (wptr_gray !== 10'h002) begin bad++; $display("FAIL midop_resume_gray: got %0h exp 2", wptr_gray); end
        total++; if (wr_level !== 10'd3) begin bad++; $display("FAIL midop_resume_level: got %0d exp 3", wr_level); end
    endtask

    initial begin
        repeat (SYNC) q.push_back(0);
        test_reset();
        test_five_writes();
        test_fill();
        test_release();
        test_wrap_random();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
